pic_ctrl_sequencer: RTL and testbench

PIC_CTRL_SEQUENCER -- requirements
Module: pic_ctrl_sequencer

---
 rtl/pic_pkg.sv | 32 +++
 rtl/pic_bus_writer.sv | 77 +++++++
 rtl/pic_ctrl_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pic_ctrl_sequencer.sv | 526 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and OCW2 command constants for the 8259 PIC control sequencer.
// Both the sequencer and its bus writer import this package.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_ICW1,
        ST_ICW2,
        ST_ICW4,
        ST_OCW1,
        ST_READY,
        ST_WR_MASK,
        ST_WR_EOI
    } pic_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_STROBE,
        WR_GAP
    } wr_state_t;

    localparam logic [7:0] EOI_NS   = 8'h20;
    localparam logic [7:0] EOI_SPEC = 8'h60;

    localparam logic PIC_ADDR_CMD  = 1'b0;
    localparam logic PIC_ADDR_DATA = 1'b1;

    // Specific EOI carries the level in the low three bits of OCW2.
    function automatic logic [7:0] ocw2_eoi(input logic specific, input logic [2:0] level);
        return specific ? (EOI_SPEC | {5'b00000, level}) : EOI_NS;
    endfunction

endpackage

// File: rtl/pic_bus_writer.sv
// Performs one PIC register write: holds the strobes until pic_ack or timeout,
// then forces a single idle gap cycle before the next write may start.
module pic_bus_writer
    import pic_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        addr,
    input  logic [7:0]  data,
    input  logic        pic_ack,
    output logic        pic_cs,
    output logic        pic_we,
    output logic        pic_addr,
    output logic [15:0] pic_wdata,
    output logic        done,
    output logic        timed_out,
    output logic        active
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] ACK_LIMIT = CW'(ACK_TIMEOUT - 1);

    wr_state_t     wr_state;
    logic [CW-1:0] ack_cnt;
    logic          limit_hit;

    // The counter holds the number of strobe cycles already elapsed, so the
    // strobes stay up for exactly ACK_TIMEOUT cycles before being abandoned.
    assign limit_hit = (ack_cnt == ACK_LIMIT);
    assign done      = (wr_state == WR_STROBE) && (pic_ack || limit_hit);
    assign timed_out = (wr_state == WR_STROBE) && !pic_ack && limit_hit;
    assign active    = (wr_state != WR_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state  <= WR_IDLE;
            pic_cs    <= 1'b0;
            pic_we    <= 1'b0;
            pic_addr  <= 1'b0;
            pic_wdata <= 16'h0000;
            ack_cnt   <= '0;
        end else begin
            case (wr_state)
                WR_IDLE, WR_GAP: begin
                    if (go) begin
                        wr_state  <= WR_STROBE;
                        pic_cs    <= 1'b1;
                        pic_we    <= 1'b1;
                        pic_addr  <= addr;
                        pic_wdata <= {8'h00, data};
                        ack_cnt   <= '0;
                    end else begin
                        wr_state <= WR_IDLE;
                    end
                end
                WR_STROBE: begin
                    if (pic_ack || limit_hit) begin
                        wr_state <= WR_GAP;
                        pic_cs   <= 1'b0;
                        pic_we   <= 1'b0;
                    end else begin
                        ack_cnt <= ack_cnt + CW'(1);
                    end
                end
                default: begin
                    wr_state <= WR_IDLE;
                    pic_cs   <= 1'b0;
                    pic_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pic_ctrl_sequencer.sv
// Initialises an 8259-style PIC (ICW1/ICW2/ICW4/OCW1) and then serves queued
// EOI, mask and re-initialise requests through a single bus writer.
module pic_ctrl_sequencer
    import pic_pkg::*;
#(
    parameter logic [7:0] ICW1_VAL    = 8'h13,
    parameter logic [7:0] ICW2_VAL    = 8'h08,
    parameter logic [7:0] ICW4_VAL    = 8'h01,
    parameter logic [7:0] OCW1_INIT   = 8'hFF,
    parameter int         ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mask_req,
    input  logic [7:0]  mask_data,
    output logic        mask_ack,
    input  logic        eoi_req,
    input  logic        eoi_specific,
    input  logic [2:0]  eoi_level,
    output logic        eoi_ack,
    output logic        pic_cs,
    output logic        pic_we,
    output logic        pic_addr,
    output logic [15:0] pic_wdata,
    input  logic        pic_ack,
    output logic        init_done,
    output logic        busy,
    output logic        timeout_err
);

    pic_state_t state;
    logic       go;
    logic       wr_addr;
    logic [7:0] wr_data;
    logic       wr_done;
    logic       wr_timed_out;
    logic       wr_active;
    logic       mask_pend;
    logic       eoi_pend;
    logic       start_pend;

    pic_bus_writer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_writer (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .addr      (wr_addr),
        .data      (wr_data),
        .pic_ack   (pic_ack),
        .pic_cs    (pic_cs),
        .pic_we    (pic_we),
        .pic_addr  (pic_addr),
        .pic_wdata (pic_wdata),
        .done      (wr_done),
        .timed_out (wr_timed_out),
        .active    (wr_active)
    );

    // go is still high in the cycle before the writer raises its strobes.
    assign busy = (state != ST_READY) || wr_active || go;

    // Each state transition that needs a write loads wr_addr/wr_data and pulses
    // go in the same edge, so the writer launches the next write right out of
    // its gap cycle. Reset itself counts as entering ICW1, hence go resets high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_ICW1;
            go          <= 1'b1;
            wr_addr     <= PIC_ADDR_CMD;
            wr_data     <= ICW1_VAL;
            mask_pend   <= 1'b0;
            eoi_pend    <= 1'b0;
            start_pend  <= 1'b0;
            init_done   <= 1'b0;
            timeout_err <= 1'b0;
            mask_ack    <= 1'b0;
            eoi_ack     <= 1'b0;
        end else begin
            go         <= 1'b0;
            mask_ack   <= 1'b0;
            eoi_ack    <= 1'b0;
            mask_pend  <= mask_pend | mask_req;
            eoi_pend   <= eoi_pend | eoi_req;
            start_pend <= start_pend | start;
            if (wr_timed_out) begin
                timeout_err <= 1'b1;
            end

            case (state)
                ST_ICW1: begin
                    if (wr_done) begin
                        state   <= ST_ICW2;
                        go      <= 1'b1;
                        wr_addr <= PIC_ADDR_DATA;
                        wr_data <= ICW2_VAL;
                    end
                end
                ST_ICW2: begin
                    if (wr_done) begin
                        state   <= ST_ICW4;
                        go      <= 1'b1;
                        wr_addr <= PIC_ADDR_DATA;
                        wr_data <= ICW4_VAL;
                    end
                end
                ST_ICW4: begin
                    if (wr_done) begin
                        state   <= ST_OCW1;
                        go      <= 1'b1;
                        wr_addr <= PIC_ADDR_DATA;
                        wr_data <= OCW1_INIT;
                    end
                end
                ST_OCW1: begin
                    if (wr_done) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end
                end
                // Re-init outranks EOI, which outranks a mask update.
                ST_READY: begin
                    if (start_pend) begin
                        state       <= ST_ICW1;
                        go          <= 1'b1;
                        wr_addr     <= PIC_ADDR_CMD;
                        wr_data     <= ICW1_VAL;
                        start_pend  <= start;
                        init_done   <= 1'b0;
                        timeout_err <= 1'b0;
                    end else if (eoi_pend) begin
                        state   <= ST_WR_EOI;
                        go      <= 1'b1;
                        wr_addr <= PIC_ADDR_CMD;
                        wr_data <= ocw2_eoi(eoi_specific, eoi_level);
                    end else if (mask_pend) begin
                        state   <= ST_WR_MASK;
                        go      <= 1'b1;
                        wr_addr <= PIC_ADDR_DATA;
                        wr_data <= mask_data;
                    end
                end
                ST_WR_MASK: begin
                    if (wr_done) begin
                        state     <= ST_READY;
                        mask_ack  <= 1'b1;
                        mask_pend <= mask_req;
                    end
                end
                ST_WR_EOI: begin
                    if (wr_done) begin
                        state    <= ST_READY;
                        eoi_ack  <= 1'b1;
                        eoi_pend <= eoi_req;
                    end
                end
                default: begin
                    state <= ST_ICW1;
                    go    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_ctrl_sequencer.sv
// Self-checking bench for pic_ctrl_sequencer: a PIC responder, a bus monitor and
// a write-list reference model built from the init/EOI/mask command rules.
module tb_pic_ctrl_sequencer;

    localparam logic [15:0] ICW1_EXP = 16'h0013;
    localparam logic [15:0] ICW2_EXP = 16'h0008;
    localparam logic [15:0] ICW4_EXP = 16'h0001;
    localparam logic [15:0] OCW1_EXP = 16'h00FF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mask_req = 1'b0;
    logic [7:0]  mask_data = 8'h00;
    logic        eoi_req = 1'b0;
    logic        eoi_specific = 1'b0;
    logic [2:0]  eoi_level = 3'd0;
    logic        pic_ack;
    logic        mask_ack, eoi_ack, pic_cs, pic_we, pic_addr;
    logic [15:0] pic_wdata;
    logic        init_done, busy, timeout_err;

    int compared = 0;
    int mismatched = 0;

    int ack_delay = 2;
    int nack_left = 0;
    int hi_cnt = 0;
    bit cur_nack = 0;

    logic [16:0] obs_w[$];
    logic [16:0] exp_w[$];
    int          obs_gap[$];
    int          to_dur[$];
    bit          obs_idone[$];
    int          eoi_pulses, mask_pulses, stab_err, to_cnt;
    logic        prev_cs = 1'b0;
    logic        prev_addr = 1'b0;
    logic [15:0] prev_wdata = 16'h0;
    bit          have_prev = 0;
    int          low_cnt = 0;
    int          cur_dur = 0;

    pic_ctrl_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mask_req     (mask_req),
        .mask_data    (mask_data),
        .mask_ack     (mask_ack),
        .eoi_req      (eoi_req),
        .eoi_specific (eoi_specific),
        .eoi_level    (eoi_level),
        .eoi_ack      (eoi_ack),
        .pic_cs       (pic_cs),
        .pic_we       (pic_we),
        .pic_addr     (pic_addr),
        .pic_wdata    (pic_wdata),
        .pic_ack      (pic_ack),
        .init_done    (init_done),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // PIC responder: raises pic_ack once the strobe has been seen ack_delay
    // times; the first nack_left strobes are never acknowledged.
    initial begin
        pic_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (pic_cs) begin
                if (hi_cnt == 0) begin
                    cur_nack = (nack_left > 0);
                    if (cur_nack) nack_left--;
                end
                hi_cnt++;
                pic_ack = !cur_nack && (hi_cnt >= ack_delay);
            end else begin
                hi_cnt = 0;
                pic_ack = 1'b0;
            end
        end
    end

    // Bus monitor, sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_cs = 1'b0;
                have_prev = 0;
                low_cnt = 0;
                cur_dur = 0;
            end else begin
                if (pic_cs && !prev_cs) begin
                    if (have_prev) obs_gap.push_back(low_cnt);
                    obs_idone.push_back(init_done);
                    cur_dur = 0;
                end
                if (pic_cs && prev_cs && (pic_addr !== prev_addr || pic_wdata !== prev_wdata)) stab_err++;
                if (pic_cs !== pic_we) stab_err++;
                if (pic_cs) cur_dur++;
                if (prev_cs && !pic_cs) begin
                    if (pic_ack) obs_w.push_back({prev_addr, prev_wdata});
                    else begin
                        to_cnt++;
                        to_dur.push_back(cur_dur);
                    end
                    have_prev = 1;
                    low_cnt = 0;
                end
                if (!pic_cs) low_cnt++;
                if (eoi_ack) eoi_pulses++;
                if (mask_ack) mask_pulses++;
                prev_cs = pic_cs;
                prev_addr = pic_addr;
                prev_wdata = pic_wdata;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void push_init();
        exp_w.push_back({1'b0, ICW1_EXP});
        exp_w.push_back({1'b1, ICW2_EXP});
        exp_w.push_back({1'b1, ICW4_EXP});
        exp_w.push_back({1'b1, OCW1_EXP});
    endfunction

    function automatic void push_eoi(input bit specific, input int level);
        exp_w.push_back({1'b0, specific ? 16'(16'h0060 + level) : 16'h0020});
    endfunction

    function automatic void push_mask(input logic [7:0] value);
        exp_w.push_back({1'b1, 8'h00, value});
    endfunction

    task automatic clear_monitor();
        obs_w.delete();
        exp_w.delete();
        obs_gap.delete();
        to_dur.delete();
        obs_idone.delete();
        eoi_pulses = 0;
        mask_pulses = 0;
        stab_err = 0;
        to_cnt = 0;
        have_prev = 0;
    endtask

    task automatic pulse_reqs(input bit e, input bit m, input bit s);
        @(negedge clk);
        eoi_req = e;
        mask_req = m;
        start = s;
        @(negedge clk);
        eoi_req = 1'b0;
        mask_req = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        int quiet;
        n = 0;
        quiet = 0;
        repeat (3) @(negedge clk);
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (!busy && !pic_cs) quiet++;
            else quiet = 0;
        end
        compared++;
        if (quiet < 3) begin
            mismatched++;
            $display("[TB] FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic wait_strobe(input logic addr, input int budget);
        int n;
        n = 0;
        while (!(pic_cs && pic_addr == addr) && n < budget) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (!(pic_cs && pic_addr == addr)) begin
            mismatched++;
            $display("[TB] FAIL wait_strobe: no strobe to addr %0d within %0d cycles", addr, budget);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if ({pic_cs, pic_we, pic_addr, pic_wdata} !== 19'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_bus: cs=%0b we=%0b addr=%0b wdata=%04h, required all 0", pic_cs, pic_we, pic_addr, pic_wdata);
        end
        compared++;
        if ({mask_ack, eoi_ack, init_done, timeout_err} !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_status: mask_ack=%0b eoi_ack=%0b init_done=%0b timeout_err=%0b, required 0", mask_ack, eoi_ack, init_done, timeout_err);
        end
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_busy: got %0b, required 1", busy);
        end
    endtask

    task automatic test_init();
        clear_monitor();
        ack_delay = 2;
        push_init();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        compared++;
        if (pic_cs !== 1'b1 || pic_addr !== 1'b0 || pic_wdata !== ICW1_EXP) begin
            mismatched++;
            $display("[TB] FAIL init_latency: cs=%0b %0d:%04h, required cs=1 0:%04h", pic_cs, pic_addr, pic_wdata, ICW1_EXP);
        end
        wait_idle(200);
        compared++;
        if (obs_w.size() != exp_w.size()) begin
            mismatched++;
            $display("[TB] FAIL init_count: got %0d writes, required %0d", obs_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            compared++;
            if (obs_w[i] !== exp_w[i]) begin
                mismatched++;
                $display("[TB] FAIL init_write%0d: got %0d:%04h, required %0d:%04h", i, obs_w[i][16], obs_w[i][15:0], exp_w[i][16], exp_w[i][15:0]);
            end
        end
        compared++;
        if (obs_gap.size() != 3) begin
            mismatched++;
            $display("[TB] FAIL init_gap_count: got %0d, required 3", obs_gap.size());
        end
        foreach (obs_gap[i]) begin
            compared++;
            if (obs_gap[i] != 1) begin
                mismatched++;
                $display("[TB] FAIL init_gap%0d: got %0d cycles, required 1", i, obs_gap[i]);
            end
        end
        compared++;
        if (init_done !== 1'b1 || timeout_err !== 1'b0 || stab_err != 0) begin
            mismatched++;
            $display("[TB] FAIL init_status: init_done=%0b timeout_err=%0b stab_err=%0d, required 1/0/0", init_done, timeout_err, stab_err);
        end
    endtask

    task automatic test_eoi_specific();
        clear_monitor();
        ack_delay = 2;
        eoi_specific = 1'b1;
        eoi_level = 3'd3;
        push_eoi(1, 3);
        pulse_reqs(1, 0, 0);
        wait_idle(100);
        compared++;
        if (obs_w.size() != 1 || obs_w[0] !== exp_w[0]) begin
            mismatched++;
            $display("[TB] FAIL eoi_specific_write: got %0d writes first=%05h, required 1 write %05h", obs_w.size(), obs_w.size() > 0 ? obs_w[0] : 17'h0, exp_w[0]);
        end
        compared++;
        if (eoi_pulses != 1 || mask_pulses != 0) begin
            mismatched++;
            $display("[TB] FAIL eoi_specific_ack: eoi_ack cycles=%0d mask_ack cycles=%0d, required 1/0", eoi_pulses, mask_pulses);
        end
    endtask

    task automatic test_eoi_mask_same_cycle();
        clear_monitor();
        eoi_specific = 1'b0;
        mask_data = 8'hF7;
        push_eoi(0, 0);
        push_mask(8'hF7);
        pulse_reqs(1, 1, 0);
        wait_idle(100);
        compared++;
        if (obs_w.size() != exp_w.size()) begin
            mismatched++;
            $display("[TB] FAIL both_count: got %0d writes, required %0d", obs_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            compared++;
            if (obs_w[i] !== exp_w[i]) begin
                mismatched++;
                $display("[TB] FAIL both_write%0d: got %05h, required %05h", i, obs_w[i], exp_w[i]);
            end
        end
        compared++;
        if (eoi_pulses != 1 || mask_pulses != 1) begin
            mismatched++;
            $display("[TB] FAIL both_acks: eoi=%0d mask=%0d, required 1/1", eoi_pulses, mask_pulses);
        end
    endtask

    task automatic test_back_to_back();
        clear_monitor();
        ack_delay = 3;
        eoi_specific = 1'b1;
        eoi_level = 3'd5;
        mask_data = 8'h3C;
        push_eoi(1, 5);
        push_mask(8'h3C);
        push_init();
        pulse_reqs(1, 0, 0);
        wait_strobe(1'b0, 20);
        pulse_reqs(0, 1, 0);
        wait_strobe(1'b1, 40);
        pulse_reqs(0, 0, 1);
        wait_idle(300);
        compared++;
        if (obs_w.size() != exp_w.size()) begin
            mismatched++;
            $display("[TB] FAIL b2b_count: got %0d writes, required %0d", obs_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            compared++;
            if (obs_w[i] !== exp_w[i]) begin
                mismatched++;
                $display("[TB] FAIL b2b_write%0d: got %05h, required %05h", i, obs_w[i], exp_w[i]);
            end
        end
        compared++;
        if (eoi_pulses != 1 || mask_pulses != 1 || init_done !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_status: eoi=%0d mask=%0d init_done=%0b, required 1/1/1", eoi_pulses, mask_pulses, init_done);
        end
    endtask

    task automatic test_mask_during_init();
        int n;
        clear_monitor();
        ack_delay = 2;
        mask_data = 8'h5A;
        push_init();
        push_mask(8'h5A);
        pulse_reqs(0, 0, 1);
        n = 0;
        while (obs_w.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        pulse_reqs(0, 1, 0);
        wait_idle(200);
        compared++;
        if (obs_w.size() != exp_w.size()) begin
            mismatched++;
            $display("[TB] FAIL mid_init_count: got %0d writes, required %0d", obs_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            compared++;
            if (obs_w[i] !== exp_w[i]) begin
                mismatched++;
                $display("[TB] FAIL mid_init_write%0d: got %05h, required %05h", i, obs_w[i], exp_w[i]);
            end
        end
        compared++;
        if (obs_idone.size() != 5 || obs_idone[3] !== 1'b0 || obs_idone[4] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL mid_init_order: strobes=%0d, init_done at mask write must be 1 and at OCW1 0", obs_idone.size());
        end
        compared++;
        if (mask_pulses != 1) begin
            mismatched++;
            $display("[TB] FAIL mid_init_ack: mask_ack cycles=%0d, required 1", mask_pulses);
        end
    endtask

    task automatic test_timeout_and_restart();
        clear_monitor();
        ack_delay = 2;
        nack_left = 1;
        exp_w.push_back({1'b1, ICW2_EXP});
        exp_w.push_back({1'b1, ICW4_EXP});
        exp_w.push_back({1'b1, OCW1_EXP});
        pulse_reqs(0, 0, 1);
        wait_idle(1000);
        compared++;
        if (to_cnt != 1 || to_dur.size() != 1 || to_dur[0] != 255) begin
            mismatched++;
            $display("[TB] FAIL timeout_len: %0d abandoned, length %0d, required 1 of 255 cycles", to_cnt, to_dur.size() > 0 ? to_dur[0] : -1);
        end
        compared++;
        if (obs_w.size() != 3 || obs_w[0] !== exp_w[0] || obs_w[2] !== exp_w[2]) begin
            mismatched++;
            $display("[TB] FAIL timeout_proceed: got %0d acked writes, required 08/01/FF", obs_w.size());
        end
        compared++;
        if (timeout_err !== 1'b1 || init_done !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL timeout_flag: timeout_err=%0b init_done=%0b, required 1/1", timeout_err, init_done);
        end
        clear_monitor();
        push_init();
        pulse_reqs(0, 0, 1);
        @(posedge clk);
        #1;
        compared++;
        if (timeout_err !== 1'b0 || init_done !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL restart_clear: timeout_err=%0b init_done=%0b busy=%0b, required 0/0/1", timeout_err, init_done, busy);
        end
        wait_idle(200);
        compared++;
        if (obs_w.size() != 4 || obs_w[0] !== exp_w[0] || obs_w[3] !== exp_w[3] || timeout_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL restart_init: got %0d writes timeout_err=%0b, required 4 writes and 0", obs_w.size(), timeout_err);
        end
    endtask

    task automatic test_reset_mid_write();
        clear_monitor();
        ack_delay = 4;
        pulse_reqs(0, 0, 1);
        wait_strobe(1'b0, 20);
        reset = 1'b1;
        #1;
        compared++;
        if (pic_cs !== 1'b0 || pic_we !== 1'b0 || pic_wdata !== 16'h0 || busy !== 1'b1 || init_done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_write: cs=%0b we=%0b wdata=%04h busy=%0b, required 0/0/0000/1", pic_cs, pic_we, pic_wdata, busy);
        end
        repeat (3) @(negedge clk);
        clear_monitor();
        push_init();
        reset = 1'b0;
        wait_idle(200);
        compared++;
        if (obs_w.size() != exp_w.size()) begin
            mismatched++;
            $display("[TB] FAIL reinit_count: got %0d writes, required %0d", obs_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            compared++;
            if (obs_w[i] !== exp_w[i]) begin
                mismatched++;
                $display("[TB] FAIL reinit_write%0d: got %05h, required %05h", i, obs_w[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_random();
        int kind;
        int n_eoi;
        int n_mask;
        clear_monitor();
        n_eoi = 0;
        n_mask = 0;
        for (int op = 0; op < 12; op++) begin
            ack_delay = $urandom_range(1, 4);
            kind = $urandom_range(0, 5);
            eoi_specific = 1'($urandom_range(0, 1));
            eoi_level = 3'($urandom_range(0, 7));
            mask_data = 8'($urandom_range(0, 255));
            if (kind <= 1 || kind == 4) begin
                push_eoi(eoi_specific, int'(eoi_level));
                n_eoi++;
            end
            if ((kind >= 2 && kind <= 3) || kind == 4) begin
                push_mask(mask_data);
                n_mask++;
            end
            if (kind == 5) push_init();
            pulse_reqs(kind <= 1 || kind == 4, (kind >= 2 && kind <= 4), kind == 5);
            wait_idle(200);
        end
        compared++;
        if (obs_w.size() != exp_w.size()) begin
            mismatched++;
            $display("[TB] FAIL random_count: got %0d writes, required %0d", obs_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            compared++;
            if (obs_w[i] !== exp_w[i]) begin
                mismatched++;
                $display("[TB] FAIL random_write%0d: got %05h, required %05h", i, obs_w[i], exp_w[i]);
            end
        end
        compared++;
        if (eoi_pulses != n_eoi || mask_pulses != n_mask || stab_err != 0) begin
            mismatched++;
            $display("[TB] FAIL random_acks: eoi=%0d/%0d mask=%0d/%0d stab_err=%0d", eoi_pulses, n_eoi, mask_pulses, n_mask, stab_err);
        end
        foreach (obs_gap[i]) begin
            compared++;
            if (obs_gap[i] < 1) begin
                mismatched++;
                $display("[TB] FAIL random_gap%0d: got %0d idle cycles, required at least 1", i, obs_gap[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_eoi_specific();
        test_eoi_mask_same_cycle();
        test_back_to_back();
        test_mask_during_init();
        test_timeout_and_restart();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
